// File: rtl/ov7670_cfg_sequencer_if.sv
// ov7670_cfg_sequencer_if: register-table read port plus camera-unit I2C and pixel handshakes.
interface ov7670_cfg_sequencer_if #(
  parameter int AW = 8
);
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic          i2c_start_en;
  logic [7:0]    i2c_addr_o;
  logic [7:0]    i2c_data_o;
  logic [31:0]   delay_o;
  logic          i2c_ready_i;
  logic          pxl_start_en;
  logic          pxl_idle_i;
  modport master (
    output tbl_addr, i2c_start_en, i2c_addr_o, i2c_data_o, delay_o, pxl_start_en,
    input  tbl_data, i2c_ready_i, pxl_idle_i
  );
  modport slave (
    input  tbl_addr, i2c_start_en, i2c_addr_o, i2c_data_o, delay_o, pxl_start_en,
    output tbl_data, i2c_ready_i, pxl_idle_i
  );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer: walks a register table into OV7670 I2C writes, then arms frame capture.
module ov7670_cfg_sequencer #(
  parameter int          TBL_DEPTH  = 256,
  parameter int          DELAY_UNIT = 1000,
  parameter int          TIMEOUT    = 2000000,
  parameter logic [31:0] I2C_DELAY  = 32'd500,
  localparam int         AW         = $clog2(TBL_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic                   cap_req,
  input  logic                   abort,
  ov7670_cfg_sequencer_if.master cam,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   frame_done,
  output logic                   err,
  output logic [AW:0]            entry_cnt
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, I2C_REQ, I2C_WAIT, DLY, NEXT, CFG_DONE, CAP_REQ, CAP_WAIT, ERROR
  } state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   ent_q, ent_d;
  logic [31:0]   tmr_q, tmr_d;
  logic [7:0]    wdat_q, wdat_d, ra_q, ra_d, rd_q, rd_d;
  logic          start_q, start_d, pxl_q, pxl_d, fd_q, fd_d;
  logic          timed_out, last, is_end, is_wait, can_start;
  assign timed_out = tmr_q == 32'(TIMEOUT - 1);
  assign last      = addr_q == AW'(TBL_DEPTH - 1);
  assign is_end    = cam.tbl_data == 16'hFFFF;
  assign is_wait   = cam.tbl_data[15:8] == 8'hF0;
  assign can_start = state_q == IDLE || state_q == CFG_DONE || state_q == ERROR;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ent_d   = ent_q;
    wdat_d  = wdat_q;
    ra_d    = ra_q;
    rd_d    = rd_q;
    start_d = start_q;
    pxl_d   = pxl_q;
    fd_d    = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        state_d = is_end ? CFG_DONE : is_wait ? DLY : I2C_REQ;
        wdat_d  = cam.tbl_data[7:0];
        if (!is_end && !is_wait) {ra_d, rd_d} = cam.tbl_data;
      end
      I2C_REQ: begin
        if (timed_out) begin
          state_d = ERROR;
          start_d = 1'b0;
        end else if (start_q && !cam.i2c_ready_i) begin
          state_d = I2C_WAIT;
          start_d = 1'b0;
        end else if (cam.i2c_ready_i) start_d = 1'b1;
      end
      I2C_WAIT: begin
        if (timed_out) state_d = ERROR;
        else if (cam.i2c_ready_i) begin
          state_d = NEXT;
          ent_d   = ent_q + (AW+1)'(1);
        end
      end
      DLY:  if (tmr_q >= 32'(wdat_q) * 32'(DELAY_UNIT)) state_d = NEXT;
      // the last slot ends the walk even without an end marker; the address never wraps
      NEXT: begin
        state_d = last ? CFG_DONE : FETCH;
        addr_d  = last ? addr_q : addr_q + AW'(1);
      end
      CFG_DONE: if (cap_req && !cfg_start) begin
        state_d = CAP_REQ;
        pxl_d   = 1'b1;
      end
      CAP_REQ:  if (!cam.pxl_idle_i) state_d = CAP_WAIT;
      CAP_WAIT: if (cam.pxl_idle_i) begin
        state_d = CFG_DONE;
        pxl_d   = 1'b0;
        fd_d    = 1'b1;
      end
      default: ;
    endcase
    if (cfg_start && can_start) begin
      state_d = FETCH;
      addr_d  = '0;
      ent_d   = '0;
    end
    if (abort) begin
      state_d = IDLE;
      addr_d  = addr_q;
      ent_d   = ent_q;
      start_d = 1'b0;
      pxl_d   = 1'b0;
      fd_d    = 1'b0;
    end
  end
  assign tmr_d = state_d != state_q ? '0 : tmr_q + {31'd0, ~&tmr_q};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ent_q   <= '0;
      tmr_q   <= '0;
      wdat_q  <= '0;
      ra_q    <= '0;
      rd_q    <= '0;
      start_q <= 1'b0;
      pxl_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ent_q   <= ent_d;
      tmr_q   <= tmr_d;
      wdat_q  <= wdat_d;
      ra_q    <= ra_d;
      rd_q    <= rd_d;
      start_q <= start_d;
      pxl_q   <= pxl_d;
      fd_q    <= fd_d;
    end
  end
  assign cam.tbl_addr     = addr_q;
  assign cam.i2c_start_en = start_q;
  assign cam.i2c_addr_o   = ra_q;
  assign cam.i2c_data_o   = rd_q;
  assign cam.delay_o      = I2C_DELAY;
  assign cam.pxl_start_en = pxl_q;
  assign busy             = !can_start;
  assign cfg_done         = state_q == CFG_DONE;
  assign err              = state_q == ERROR;
  assign frame_done       = fd_q;
  assign entry_cnt        = ent_q;
endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// tb_ov7670_cfg_sequencer: random register tables, waits, timeout, capture and abort scenarios
// checked against a table-level model of the expected I2C write stream.
module tb_ov7670_cfg_sequencer;
  localparam int DEPTH = 4, DU = 10, TO = 100;
  logic clk = 1'b0, reset, cfg_start, cap_req, abort, busy, cfg_done, frame_done, err;
  logic [2:0] entry_cnt;
  ov7670_cfg_sequencer_if #(.AW(2)) cam ();
  ov7670_cfg_sequencer #(.TBL_DEPTH(DEPTH), .DELAY_UNIT(DU), .TIMEOUT(TO), .I2C_DELAY(32'd500)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cap_req(cap_req), .abort(abort), .cam(cam),
    .busy(busy), .cfg_done(cfg_done), .frame_done(frame_done), .err(err), .entry_cnt(entry_cnt)
  );
  always #5 clk = ~clk;
  logic [15:0] tbl [DEPTH];
  logic [1:0]  rom_addr;
  logic [15:0] wq[$], exp_w[$];
  int st_q[$], dn_q[$], exp_gap[$];
  int cyc, busy_len, hang_after, i2c_left, frame_len, pxl_left, fd_cnt, pxl_viol, pxl_seen, idle_low;
  int vecs, errs;
  bit ok;
  // camera unit + synchronous table ROM, updated on the falling edge
  initial begin
    cam.i2c_ready_i = 1'b1;
    cam.pxl_idle_i  = 1'b1;
    cam.tbl_data    = '0;
    rom_addr        = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_done) fd_cnt++;
      if (cam.pxl_start_en) pxl_seen++;
      if (!cam.pxl_idle_i) begin
        idle_low++;
        if (!cam.pxl_start_en) pxl_viol++;
      end
      cam.tbl_data = tbl[rom_addr];
      rom_addr = cam.tbl_addr;
      if (i2c_left > 0) i2c_left--;
      else if (!cam.i2c_ready_i) begin
        if (hang_after == 0 || wq.size() < hang_after) begin
          cam.i2c_ready_i = 1'b1;
          dn_q.push_back(cyc);
        end
      end else if (cam.i2c_start_en) begin
        wq.push_back({cam.i2c_addr_o, cam.i2c_data_o});
        st_q.push_back(cyc);
        cam.i2c_ready_i = 1'b0;
        i2c_left = busy_len;
      end
      if (pxl_left > 0) begin
        pxl_left--;
        if (pxl_left == 0) cam.pxl_idle_i = 1'b1;
      end else if (cam.pxl_idle_i && cam.pxl_start_en) begin
        cam.pxl_idle_i = 1'b0;
        pxl_left = frame_len;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want summary");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic pulse(input logic s, input logic c, input logic a);
    cfg_start = s;
    cap_req   = c;
    abort     = a;
    tick();
    cfg_start = 1'b0;
    cap_req   = 1'b0;
    abort     = 1'b0;
  endtask
  task automatic wait_idle(output bit done);
    done = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (!busy) begin
        done = 1'b1;
        return;
      end
      tick();
    end
  endtask
  task automatic clear_log();
    wq.delete();
    st_q.delete();
    dn_q.delete();
    fd_cnt = 0;
    pxl_viol = 0;
    pxl_seen = 0;
    idle_low = 0;
  endtask
  // expected write stream and minimum pre-write wait, straight from the table encoding
  task automatic model();
    int acc;
    acc = 0;
    exp_w.delete();
    exp_gap.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl[i] == 16'hFFFF) break;
      if (tbl[i][15:8] == 8'hF0) acc += int'(tbl[i][7:0]);
      else begin
        exp_w.push_back(tbl[i]);
        exp_gap.push_back(acc * DU);
        acc = 0;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vecs++;
    if ({cam.i2c_start_en, cam.pxl_start_en, busy, cfg_done, frame_done, err} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 000000", {cam.i2c_start_en, cam.pxl_start_en, busy, cfg_done, frame_done, err});
    end
    vecs++;
    if (entry_cnt !== 3'd0 || cam.tbl_addr !== 2'd0) begin
      errs++;
      $display("FAIL reset_counters got cnt=%0d addr=%0d want 0 0", entry_cnt, cam.tbl_addr);
    end
    vecs++;
    if (cam.i2c_addr_o !== 8'd0 || cam.i2c_data_o !== 8'd0 || cam.delay_o !== 32'd500) begin
      errs++;
      $display("FAIL reset_bus got %h/%h/%0d want 00/00/500", cam.i2c_addr_o, cam.i2c_data_o, cam.delay_o);
    end
    reset = 1'b0;
    repeat (2) tick();
    vecs++;
    if (busy !== 1'b0 || cam.i2c_start_en !== 1'b0) begin
      errs++;
      $display("FAIL reset_release got busy=%b start=%b want 0 0", busy, cam.i2c_start_en);
    end
  endtask
  task automatic test_basic();
    tbl = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    busy_len = 10;
    clear_log();
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle(ok);
    vecs++;
    if (!ok || wq.size() != 2 || wq[0] !== 16'h1280 || wq[1] !== 16'h1101) begin
      errs++;
      $display("FAIL basic_writes got done=%b n=%0d %h %h want 1 2 1280 1101", ok, wq.size(), wq[0], wq[1]);
    end
    vecs++;
    if (entry_cnt !== 3'd2 || cfg_done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_status got cnt=%0d done=%b busy=%b want 2 1 0", entry_cnt, cfg_done, busy);
    end
  endtask
  task automatic test_wait_entry();
    int gap;
    tbl = '{16'h1280, 16'hF003, 16'h1101, 16'hFFFF};
    busy_len = 10;
    clear_log();
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle(ok);
    gap = (st_q.size() > 1 && dn_q.size() > 0) ? st_q[1] - dn_q[0] : -1;
    vecs++;
    if (!ok || wq.size() != 2 || wq[1] !== 16'h1101 || entry_cnt !== 3'd2) begin
      errs++;
      $display("FAIL wait_writes got done=%b n=%0d cnt=%0d want 1 2 2", ok, wq.size(), entry_cnt);
    end
    vecs++;
    if (gap < 30 || gap > 60) begin
      errs++;
      $display("FAIL wait_gap got %0d cycles want 30..60", gap);
    end
  endtask
  task automatic test_random_tables();
    int r, bad;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 9);
        tbl[i] = r == 0 ? 16'hFFFF : r < 3 ? {8'hF0, 8'($urandom_range(0, 3))}
                                           : {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
      end
      model();
      busy_len = $urandom_range(1, 12);
      clear_log();
      pulse(1'b1, 1'b0, 1'b0);
      wait_idle(ok);
      vecs++;
      if (!ok || cfg_done !== 1'b1 || entry_cnt !== 3'(exp_w.size())) begin
        errs++;
        $display("FAIL rand_status[%0d] got done=%b cfg=%b cnt=%0d want 1 1 %0d", it, ok, cfg_done, entry_cnt, exp_w.size());
      end
      bad = wq.size() != exp_w.size() ? 1 : 0;
      for (int k = 0; k < exp_w.size() && bad == 0; k++) if (wq[k] !== exp_w[k]) bad = k + 2;
      vecs++;
      if (bad != 0) begin
        errs++;
        $display("FAIL rand_writes[%0d] got n=%0d first=%h want n=%0d first=%h", it, wq.size(), wq[0], exp_w.size(), exp_w[0]);
      end
      bad = 0;
      for (int k = 1; k < exp_w.size() && k < st_q.size() && k <= dn_q.size(); k++)
        if (st_q[k] - dn_q[k-1] < exp_gap[k] || st_q[k] - dn_q[k-1] > exp_gap[k] + 20) bad = k;
      vecs++;
      if (bad != 0) begin
        errs++;
        $display("FAIL rand_gap[%0d] write %0d got %0d want %0d..%0d", it, bad, st_q[bad] - dn_q[bad-1], exp_gap[bad], exp_gap[bad] + 20);
      end
    end
  endtask
  task automatic test_no_end_marker();
    tbl = '{16'h1201, 16'h1302, 16'h1403, 16'h1504};
    busy_len = 4;
    clear_log();
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle(ok);
    repeat (50) tick();
    vecs++;
    if (!ok || wq.size() != 4 || wq[0] !== 16'h1201 || wq[3] !== 16'h1504) begin
      errs++;
      $display("FAIL noend_writes got done=%b n=%0d last=%h want 1 4 1504", ok, wq.size(), wq[3]);
    end
    vecs++;
    if (entry_cnt !== 3'd4 || cfg_done !== 1'b1 || busy !== 1'b0 || cam.tbl_addr !== 2'd3) begin
      errs++;
      $display("FAIL noend_status got cnt=%0d done=%b busy=%b addr=%0d want 4 1 0 3", entry_cnt, cfg_done, busy, cam.tbl_addr);
    end
  endtask
  task automatic test_timeout();
    int n;
    tbl = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    busy_len = 5;
    hang_after = 2;
    clear_log();
    pulse(1'b1, 1'b0, 1'b0);
    for (n = 0; n < 200 && wq.size() < 2; n++) tick();
    vecs++;
    if (wq.size() != 2) begin
      errs++;
      $display("FAIL tmo_reach got %0d writes want 2", wq.size());
    end
    for (n = 0; n < 300 && !err; n++) tick();
    vecs++;
    if (n < TO || n > TO + 4) begin
      errs++;
      $display("FAIL tmo_latency got %0d cycles want %0d..%0d", n, TO, TO + 4);
    end
    vecs++;
    if (err !== 1'b1 || cam.i2c_start_en !== 1'b0 || busy !== 1'b0 || cfg_done !== 1'b0 || entry_cnt !== 3'd1) begin
      errs++;
      $display("FAIL tmo_state got err=%b start=%b busy=%b done=%b cnt=%0d want 1 0 0 0 1", err, cam.i2c_start_en, busy, cfg_done, entry_cnt);
    end
    hang_after = 0;
    repeat (3) tick();
    clear_log();
    pulse(1'b1, 1'b0, 1'b0);
    vecs++;
    if (cam.tbl_addr !== 2'd0 || err !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL tmo_restart got addr=%0d err=%b busy=%b want 0 0 1", cam.tbl_addr, err, busy);
    end
    wait_idle(ok);
    vecs++;
    if (!ok || entry_cnt !== 3'd2 || wq.size() != 2 || wq[0] !== 16'h1280) begin
      errs++;
      $display("FAIL tmo_rewalk got done=%b cnt=%0d n=%0d first=%h want 1 2 2 1280", ok, entry_cnt, wq.size(), wq[0]);
    end
  endtask
  task automatic test_capture();
    int n;
    frame_len = 500;
    clear_log();
    pulse(1'b0, 1'b1, 1'b0);
    vecs++;
    if (cam.pxl_start_en !== 1'b1 || busy !== 1'b1 || cfg_done !== 1'b0) begin
      errs++;
      $display("FAIL cap_arm got pxl=%b busy=%b done=%b want 1 1 0", cam.pxl_start_en, busy, cfg_done);
    end
    for (n = 0; n < 1000 && fd_cnt == 0; n++) tick();
    repeat (3) tick();
    vecs++;
    if (fd_cnt != 1 || pxl_viol != 0 || idle_low < 500) begin
      errs++;
      $display("FAIL cap_frame got pulses=%0d drops=%0d low=%0d want 1 0 >=500", fd_cnt, pxl_viol, idle_low);
    end
    vecs++;
    if (cam.pxl_start_en !== 1'b0 || cfg_done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL cap_return got pxl=%b done=%b busy=%b want 0 1 0", cam.pxl_start_en, cfg_done, busy);
    end
  endtask
  task automatic test_abort();
    int n;
    tbl = '{16'h1280, 16'h1101, 16'h1302, 16'hFFFF};
    busy_len = 10;
    clear_log();
    pulse(1'b1, 1'b0, 1'b0);
    for (n = 0; n < 200 && wq.size() < 2; n++) tick();
    repeat (2) tick();
    pulse(1'b0, 1'b0, 1'b1);
    vecs++;
    if ({cam.i2c_start_en, cam.pxl_start_en, busy, cfg_done, err} !== 5'b0 || entry_cnt !== 3'd1) begin
      errs++;
      $display("FAIL abort_state got flags=%b cnt=%0d want 00000 1", {cam.i2c_start_en, cam.pxl_start_en, busy, cfg_done, err}, entry_cnt);
    end
    repeat (20) tick();
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    vecs++;
    if (busy !== 1'b0 || cam.pxl_start_en !== 1'b0 || wq.size() != 2 || entry_cnt !== 3'd1) begin
      errs++;
      $display("FAIL abort_hold got busy=%b pxl=%b n=%0d cnt=%0d want 0 0 2 1", busy, cam.pxl_start_en, wq.size(), entry_cnt);
    end
  endtask
  task automatic test_back_to_back();
    tbl = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    busy_len = 10;
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle(ok);
    clear_log();
    pulse(1'b1, 1'b1, 1'b0);
    vecs++;
    if (busy !== 1'b1 || cfg_done !== 1'b0 || cam.pxl_start_en !== 1'b0 || entry_cnt !== 3'd0) begin
      errs++;
      $display("FAIL b2b_priority got busy=%b done=%b pxl=%b cnt=%0d want 1 0 0 0", busy, cfg_done, cam.pxl_start_en, entry_cnt);
    end
    repeat (3) tick();
    pulse(1'b0, 1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle(ok);
    vecs++;
    if (!ok || wq.size() != 2 || wq[0] !== 16'h1280 || wq[1] !== 16'h1101 || pxl_seen != 0) begin
      errs++;
      $display("FAIL b2b_ignored got done=%b n=%0d pxl_cycles=%0d want 1 2 0", ok, wq.size(), pxl_seen);
    end
    vecs++;
    if (entry_cnt !== 3'd2 || cfg_done !== 1'b1) begin
      errs++;
      $display("FAIL b2b_status got cnt=%0d done=%b want 2 1", entry_cnt, cfg_done);
    end
  endtask
  initial begin
    reset = 1'b1;
    cfg_start = 1'b0;
    cap_req = 1'b0;
    abort = 1'b0;
    busy_len = 10;
    frame_len = 500;
    for (int i = 0; i < DEPTH; i++) tbl[i] = 16'hFFFF;
    test_reset();
    test_basic();
    test_wait_entry();
    test_random_tables();
    test_no_end_marker();
    test_timeout();
    test_capture();
    test_abort();
    test_back_to_back();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
